pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the MIPS core fetch stage. It holds the current fetch address and by default advances it by a fixed increment each cycle. It also supports stall, branch, jump, exception entry and exception return (ERET), with a fixed priority between them. It drives the instruction-memory address, the PC+increment value used by link/branch logic, a one-cycle flush pulse for the pipeline, and the saved exception PC (EPC).

## Interface
Parameters:
- ADDR_W, 32, width of all address buses.
- INC, 4, byte increment per sequential fetch.
- RESET_VEC, 'h0000_0000, PC value loaded on reset.
- EXC_VEC, 'h0000_0180, PC value loaded on exception entry.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold the PC (sequential advance suppressed).
- i_branch  in  1  branch taken this cycle.
- i_branch_tgt  in  ADDR_W  branch target address.
- i_jump  in  1  jump this cycle.
- i_jump_tgt  in  ADDR_W  jump target address.
- i_exc  in  1  exception raised this cycle.
- i_exc_pc  in  ADDR_W  address of the faulting instruction.
- i_eret  in  1  return from exception.
- o_pc  out  ADDR_W  current fetch address (registered).
- o_pc_next_seq  out  ADDR_W  o_pc + INC, combinational, modulo 2^ADDR_W.
- o_epc  out  ADDR_W  saved exception PC (registered).
- o_flush  out  1  one-cycle pulse: o_pc was just redirected.
- o_align_err  out  1  one-cycle pulse: the redirect target had nonzero low bits.

## Operation
- Each rising edge evaluates, in strict priority, reset > exc > eret > jump > branch > stall > sequential.
  - **reset**: o_pc <= RESET_VEC; o_epc <= 0; o_flush <= 0; o_align_err <= 0.
  - **exc**: o_pc <= EXC_VEC; o_epc <= i_exc_pc with bits [1:0] cleared; o_flush <= 1.
  - **eret**: o_pc <= o_epc; o_flush <= 1; o_epc unchanged.
  - **jump**: o_pc <= i_jump_tgt with [1:0] cleared; o_flush <= 1.
  - **branch**: o_pc <= i_branch_tgt with [1:0] cleared; o_flush <= 1.
  - **stall**: o_pc holds its value; o_flush <= 0.
  - **sequential**: o_pc <= o_pc + INC, truncated to ADDR_W (wraps to 0); o_flush <= 0.
- Redirects (exc, eret, jump, branch) override i_stall: the stalled instruction is flushed.
- o_align_err <= 1 for the edge where the selected jump or branch target has [1:0] != 0; otherwise 0.
  - It is not raised for exc (i_exc_pc is only masked) or for eret.
- Lower-priority requests presented in the same cycle are dropped. The block does not queue them.
- o_epc changes only on reset or exc.
- The block has two effective states, RUN (sequential or stall) and REDIRECT. The REDIRECT cycle is visible as o_flush = 1 and lasts exactly one cycle unless another redirect follows.

## Timing
- Latency: any request sampled at edge N is reflected in o_pc, o_flush, o_epc and o_align_err after edge N. There is no combinational path from inputs to o_pc.
- o_pc_next_seq follows o_pc combinationally, with zero latency.
- Back-to-back redirects on consecutive edges are legal. o_flush stays high for each of them.
- Reset applied mid-redirect wins immediately: o_flush = 0 after that edge.
- Exc and eret in the same cycle: exc wins, and EPC takes the new i_exc_pc.
- Wrap: o_pc = 'hFFFF_FFFC with INC = 4 advances to 'h0000_0000 with no flag.
- Out-of-reset: the first cycle with i_rst = 0 and no requests produces RESET_VEC + INC at the next edge.

## Test plan
- Reset then 3 idle cycles: o_pc sequence 0, 4, 8, C; o_flush and o_align_err stay 0; o_epc = 0.
- Stall for 2 cycles at o_pc = 8: o_pc holds 8, 8, then 'hC after the stall is released.
- Branch and stall together, tgt 'h40: o_pc = 'h40 and o_flush = 1 for one cycle; the next cycle gives 'h44 with o_flush = 0.
- Jump to 'h103: o_pc = 'h100, o_align_err = 1 and o_flush = 1 for one cycle.
- Exc with i_exc_pc = 'h2C, with jump, branch and eret also asserted: o_pc = 'h180, o_epc = 'h2C. Two cycles later, eret alone gives o_pc = 'h2C and o_flush = 1.
- Wrap: load 'hFFFF_FFF8 via jump, then idle: o_pc goes 'hFFFF_FFF8, 'hFFFF_FFFC, 0, 4. Asserting i_rst during a branch cycle gives o_pc = RESET_VEC and o_flush = 0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, branch, jump, exception entry and ERET.
// Priority: reset > exc > eret > jump > branch > stall > sequential.
module pc_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INC = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'('h180)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic [ADDR_W-1:0] i_branch_tgt,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_tgt,
    input  logic              i_exc,
    input  logic [ADDR_W-1:0] i_exc_pc,
    input  logic              i_eret,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next_seq,
    output logic [ADDR_W-1:0] o_epc,
    output logic              o_flush,
    output logic              o_align_err
);
    typedef enum logic {RUN, REDIRECT} state_t;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, r_epc, w_pc_next;
    logic              r_align_err, w_align_err;
    always_comb begin
        w_pc_next = i_exc ? EXC_VEC :
                    i_eret ? r_epc :
                    i_jump ? (i_jump_tgt & ALIGN_MASK) :
                    i_branch ? (i_branch_tgt & ALIGN_MASK) :
                    i_stall ? r_pc : o_pc_next_seq;
        w_state_next = (i_exc || i_eret || i_jump || i_branch) ? REDIRECT : RUN;
        // Misalignment is only reported for jump/branch targets, never exc or eret.
        w_align_err = !i_exc && !i_eret &&
                      (i_jump ? (|i_jump_tgt[1:0]) : (i_branch && (|i_branch_tgt[1:0])));
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_pc        <= RESET_VEC;
            r_epc       <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_align_err <= w_align_err;
            if (i_exc)
                r_epc <= i_exc_pc & ALIGN_MASK;
        end
    end
    assign o_pc          = r_pc;
    assign o_pc_next_seq = r_pc + ADDR_W'(INC);
    assign o_epc         = r_epc;
    assign o_flush       = (r_state == REDIRECT);
    assign o_align_err   = r_align_err;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized run against a behavioural PC model.
module tb_pc_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, exc = 1'b0, eret = 1'b0;
    logic [31:0] branch_tgt = '0, jump_tgt = '0, exc_pc = '0;
    logic [31:0] pc, pc_next_seq, epc;
    logic        flush, align_err;
    int          vec = 0, err = 0;

    pc_unit dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall),
        .i_branch(branch), .i_branch_tgt(branch_tgt),
        .i_jump(jump), .i_jump_tgt(jump_tgt),
        .i_exc(exc), .i_exc_pc(exc_pc), .i_eret(eret),
        .o_pc(pc), .o_pc_next_seq(pc_next_seq), .o_epc(epc),
        .o_flush(flush), .o_align_err(align_err)
    );

    always #5 clk = ~clk;

    // One rising edge, sample 1ns later, then drop all one-shot requests.
    task automatic tick();
        @(posedge clk);
        #1;
        {stall, branch, jump, exc, eret} = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vec++;
        if ({pc, epc, flush, align_err, pc_next_seq} !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h4}) begin
            err++;
            $display("FAIL reset: got pc=%h epc=%h flush=%b align=%b nseq=%h want 0/0/0/0/4",
                     pc, epc, flush, align_err, pc_next_seq);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vec++;
            if ({pc, flush, align_err, epc} !== {32'(4 * i), 1'b0, 1'b0, 32'h0}) begin
                err++;
                $display("FAIL idle%0d: got pc=%h flush=%b align=%b epc=%h want %h/0/0/0",
                         i, pc, flush, align_err, epc, 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1;
            tick();
            vec++;
            if ({pc, flush} !== {32'h8, 1'b0}) begin
                err++;
                $display("FAIL stall%0d: got pc=%h flush=%b want 8/0", i, pc, flush);
            end
        end
        tick();
        vec++;
        if (pc !== 32'hC) begin
            err++;
            $display("FAIL stall_release: got pc=%h want c", pc);
        end
    endtask

    task automatic test_branch_stall();
        branch = 1'b1; branch_tgt = 32'h40; stall = 1'b1;
        tick();
        vec++;
        if ({pc, flush, align_err} !== {32'h40, 1'b1, 1'b0}) begin
            err++;
            $display("FAIL br_stall: got pc=%h flush=%b align=%b want 40/1/0", pc, flush, align_err);
        end
        tick();
        vec++;
        if ({pc, flush} !== {32'h44, 1'b0}) begin
            err++;
            $display("FAIL br_after: got pc=%h flush=%b want 44/0", pc, flush);
        end
    endtask

    task automatic test_jump_align();
        jump = 1'b1; jump_tgt = 32'h103;
        tick();
        vec++;
        if ({pc, flush, align_err} !== {32'h100, 1'b1, 1'b1}) begin
            err++;
            $display("FAIL jump_align: got pc=%h flush=%b align=%b want 100/1/1", pc, flush, align_err);
        end
        tick();
        vec++;
        if ({pc, flush, align_err} !== {32'h104, 1'b0, 1'b0}) begin
            err++;
            $display("FAIL jump_after: got pc=%h flush=%b align=%b want 104/0/0", pc, flush, align_err);
        end
    endtask

    task automatic test_exc_eret();
        exc = 1'b1; exc_pc = 32'h2F; jump = 1'b1; jump_tgt = 32'h201;
        branch = 1'b1; branch_tgt = 32'h303; eret = 1'b1;
        tick();
        vec++;
        if ({pc, epc, flush, align_err} !== {32'h180, 32'h2C, 1'b1, 1'b0}) begin
            err++;
            $display("FAIL exc_all: got pc=%h epc=%h flush=%b align=%b want 180/2c/1/0",
                     pc, epc, flush, align_err);
        end
        tick();
        tick();
        vec++;
        if ({pc, flush} !== {32'h188, 1'b0}) begin
            err++;
            $display("FAIL exc_seq: got pc=%h flush=%b want 188/0", pc, flush);
        end
        eret = 1'b1; exc_pc = 32'h999;
        tick();
        vec++;
        if ({pc, epc, flush, align_err} !== {32'h2C, 32'h2C, 1'b1, 1'b0}) begin
            err++;
            $display("FAIL eret: got pc=%h epc=%h flush=%b align=%b want 2c/2c/1/0",
                     pc, epc, flush, align_err);
        end
    endtask

    task automatic test_back_to_back();
        jump = 1'b1; jump_tgt = 32'h500;
        tick();
        branch = 1'b1; branch_tgt = 32'h602;
        tick();
        vec++;
        if ({pc, flush, align_err} !== {32'h600, 1'b1, 1'b1}) begin
            err++;
            $display("FAIL b2b: got pc=%h flush=%b align=%b want 600/1/1", pc, flush, align_err);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        jump = 1'b1; jump_tgt = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if ({pc, pc_next_seq, align_err} !== {want[i], want[i] + 32'd4, 1'b0}) begin
                err++;
                $display("FAIL wrap%0d: got pc=%h nseq=%h align=%b want %h", i, pc, pc_next_seq,
                         align_err, want[i]);
            end
        end
        jump = 1'b1; jump_tgt = 32'h700;
        tick();
        branch = 1'b1; branch_tgt = 32'h800; rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if ({pc, epc, flush, align_err} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
            err++;
            $display("FAIL rst_mid: got pc=%h epc=%h flush=%b align=%b want 0/0/0/0",
                     pc, epc, flush, align_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc = 0, m_epc = 0;
        logic        m_fl = 0, m_al = 0;
        for (int n = 0; n < 400; n++) begin
            rst    = (n == 0) || ($urandom_range(0, 40) == 0);
            exc    = ($urandom_range(0, 9) == 0);
            eret   = ($urandom_range(0, 7) == 0);
            jump   = ($urandom_range(0, 6) == 0);
            branch = ($urandom_range(0, 5) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            exc_pc = $urandom;
            jump_tgt   = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
            branch_tgt = $urandom;
            if (rst) begin
                m_pc = 0; m_epc = 0; m_fl = 0; m_al = 0;
            end else if (exc) begin
                m_pc = 32'h180; m_epc = exc_pc - exc_pc % 4; m_fl = 1; m_al = 0;
            end else if (eret) begin
                m_pc = m_epc; m_fl = 1; m_al = 0;
            end else if (jump) begin
                m_pc = jump_tgt - jump_tgt % 4; m_fl = 1; m_al = (jump_tgt % 4) != 0;
            end else if (branch) begin
                m_pc = branch_tgt - branch_tgt % 4; m_fl = 1; m_al = (branch_tgt % 4) != 0;
            end else begin
                if (!stall) m_pc = m_pc + 32'd4;
                m_fl = 0; m_al = 0;
            end
            tick();
            rst = 1'b0;
            vec++;
            if ({pc, epc, flush, align_err, pc_next_seq} !== {m_pc, m_epc, m_fl, m_al, m_pc + 32'd4}) begin
                err++;
                $display("FAIL rand%0d: got pc=%h epc=%h flush=%b align=%b nseq=%h want %h/%h/%b/%b/%h",
                         n, pc, epc, flush, align_err, pc_next_seq, m_pc, m_epc, m_fl, m_al, m_pc + 32'd4);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stall();
        test_branch_stall();
        test_jump_align();
        test_exc_eret();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
